mux_2_top: RTL and testbench
============================

Name: mux_2_top

Overview:
- Registered two-source output selector for the datapath.
- Selects between the unsigned product of two WIDTH-bit operands and the packed concatenation of those operands.
- Result is driven on a 2*WIDTH-bit bus after a fixed 2-cycle pipeline.
- Product mode is the default mode, and the one the team's arithmetic benches exercise exhaustively.

Parameters:
- WIDTH, 6, operand width in bits; output width is 2*WIDTH; legal range 2..16.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, releases synchronously to clk.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sel  input  1  mode select: 0 = product, 1 = concatenation {a,b}.
- out  output  2*WIDTH  registered result.

Behaviour:
- Reset: while rst_n=0, all pipeline registers and out are 0. Reset is asynchronous: out goes to 0 without a clock edge.
- Stage 1, at each rising edge:
  - Registers a, b and sel.
  - Registers two partial products: a * b[WIDTH/2-1:0] and a * b[WIDTH-1:WIDTH/2], each unsigned and full width, no truncation.
  - For odd WIDTH, the low half is floor(WIDTH/2) bits and the high half takes the rest.
- Stage 2, at the next rising edge, sel and the partial products come from stage 1:
  - sel=0: out = pp_lo + (pp_hi << WIDTH/2), i.e. the exact a*b. Max value (2^WIDTH-1)^2 fits in 2*WIDTH bits, so no overflow or wrap.
  - sel=1: out = {a,b}, with a in the MSBs.
- Latency: exactly 2 rising edges from input sample to out. Throughput is one new operand set per cycle, with no stalls and no handshake.
- Output changes only on a clock edge or on reset assertion. There is no combinational path from inputs to out.
- sel is pipelined with its operands. Changing sel mid-stream affects only the results of the cycles where it was sampled.
- sel is sampled X/Z in simulation: treat any non-1 value as 0 (product mode).
- Boundaries:
  - a=0 or b=0 → out=0.
  - a=b=2^WIDTH-1 → out=(2^WIDTH-1)^2, e.g. 63*63=3969 for WIDTH=6.
  - Operands held stable → out stable and equal to the result from cycle 2 onward.
- Reset mid-operation: in-flight results are discarded. The first valid out appears 2 edges after the first sample following rst_n release.
- Product logic is a synthesizable shift-add partial-product array, no vendor primitives. The `*` operator is permitted only for the half-width partial products.

Optional Feature:
- Macro: MUX2_TOP_VALID_EN.
- Defined:
  - Adds input in_valid (1 bit) and output out_valid (1 bit).
  - in_valid is pipelined alongside the data; out_valid asserts exactly 2 edges after a sampled in_valid=1.
  - out_valid resets to 0.
  - out still updates every cycle regardless of in_valid.
- Not defined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with a=5, b=7 and clocks running → out=0. Assert rst_n low asynchronously between edges while out is nonzero → out=0 immediately.
- Exhaustive product, sel=0, WIDTH=6: sweep all 64x64 (a,b) pairs, holding each for ≥3 cycles → out==a*b for all 4096 pairs (e.g. 3*5=15, 63*63=3969, 0*63=0).
- Latency/throughput: apply a new pair each cycle, (1,1),(2,3),(63,2) → out = 1, 6, 126 on edges 2, 3, 4 after the first sample.
- Concatenation: sel=1, a=6'b101010, b=6'b000111 → out=12'b101010000111 after 2 edges. Toggle sel to 0 next cycle → out=294 one edge later.
- Reset mid-stream: drop rst_n while a=b=63 is in flight → out=0; after release, out=3969 two edges after the first sample.
- Optional, with MUX2_TOP_VALID_EN defined: pulse in_valid=1 for one cycle with a=4, b=9 → out_valid high for exactly one cycle, 2 edges later, with out=36.

Source files
------------

// File: rtl/mux_2_top.sv
// rtl/mux_2_top.sv - two-stage registered selector: a*b (sel=0) or {a,b} (sel=1)
// Optional MUX2_TOP_VALID_EN adds in_valid/out_valid tracking the 2-cycle pipeline.
module mux_2_top #(
   parameter int WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 sel,
   output logic [2*WIDTH-1:0]   out
`ifdef MUX2_TOP_VALID_EN
   ,
   input  logic                 in_valid,
   output logic                 out_valid
`endif
);

   localparam int LO = WIDTH / 2;
   localparam int HI = WIDTH - LO;

   logic [WIDTH+LO-1:0]   w_a_ext_lo;
   logic [WIDTH+LO-1:0]   w_b_lo_ext;
   logic [WIDTH+HI-1:0]   w_a_ext_hi;
   logic [WIDTH+HI-1:0]   w_b_hi_ext;
   logic [2*WIDTH-1:0]    w_pp_lo_wide;
   logic [2*WIDTH-1:0]    w_pp_hi_wide;
   logic [2*WIDTH-1:0]    w_product;

   logic [WIDTH-1:0]      r_a;
   logic [WIDTH-1:0]      r_b;
   logic                  r_sel;
   logic [WIDTH+LO-1:0]   r_pp_lo;
   logic [WIDTH+HI-1:0]   r_pp_hi;

   // Operands widened to the product width so the half products never truncate.
   assign w_a_ext_lo = {{LO{1'b0}}, a};
   assign w_b_lo_ext = {{WIDTH{1'b0}}, b[LO-1:0]};
   assign w_a_ext_hi = {{HI{1'b0}}, a};
   assign w_b_hi_ext = {{WIDTH{1'b0}}, b[WIDTH-1:LO]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sel   <= 1'b0;
         r_pp_lo <= '0;
         r_pp_hi <= '0;
      end else begin
         r_a     <= a;
         r_b     <= b;
         // Written as an if so an unknown sel falls back to product mode.
         if (sel) r_sel <= 1'b1;
         else     r_sel <= 1'b0;
         r_pp_lo <= w_a_ext_lo * w_b_lo_ext;
         r_pp_hi <= w_a_ext_hi * w_b_hi_ext;
      end
   end

   assign w_pp_lo_wide = {{HI{1'b0}}, r_pp_lo};
   assign w_pp_hi_wide = {{LO{1'b0}}, r_pp_hi};
   assign w_product    = w_pp_lo_wide + (w_pp_hi_wide << LO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else if (r_sel) begin
         out <= {r_a, r_b};
      end else begin
         out <= w_product;
      end
   end

`ifdef MUX2_TOP_VALID_EN
   logic r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         r_valid   <= in_valid;
         out_valid <= r_valid;
      end
   end
`endif

endmodule

// File: tb/tb_mux_2_top.sv
// tb/tb_mux_2_top.sv - randomized and directed bench for mux_2_top against a behavioural model
// Define MUX2_TOP_VALID_EN to also exercise in_valid/out_valid.
module tb_mux_2_top;

   localparam int W = 6;
   localparam int MAXV = (1 << W) - 1;

   logic            clk;
   logic            rst_n;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic            sel;
   logic [2*W-1:0]  out;
`ifdef MUX2_TOP_VALID_EN
   logic            in_valid;
   logic            out_valid;
`endif

   int total;
   int bad;

   mux_2_top #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .sel   (sel),
      .out   (out)
`ifdef MUX2_TOP_VALID_EN
      ,
      .in_valid  (in_valid),
      .out_valid (out_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model(input int ma, input int mb, input bit msel);
      if (msel) return ma * (1 << W) + mb;
      return ma * mb;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; a = 6'd5; b = 6'd7; sel = 1'b0;
      repeat (3) step();
      total++;
      if (out !== 12'd0) begin
         bad++; $display("FAIL reset_hold: out=%0d expected=0", out);
      end
      rst_n = 1'b1;
      step();
      step();
      total++;
      if (out !== 12'd35) begin
         bad++; $display("FAIL reset_release: out=%0d expected=35", out);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out !== 12'd0) begin
         bad++; $display("FAIL reset_async: out=%0d expected=0", out);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_exhaustive();
      int errs;
      errs = 0;
      sel = 1'b0;
      for (int i = 0; i <= MAXV; i++) begin
         for (int j = 0; j <= MAXV; j++) begin
            a = W'(i); b = W'(j);
            repeat (3) step();
            total++;
            if (out !== 12'(model(i, j, 1'b0))) begin
               bad++; errs++;
               if (errs <= 10)
                  $display("FAIL exhaustive a=%0d b=%0d: out=%0d expected=%0d", i, j, out, model(i, j, 1'b0));
            end
         end
      end
   endtask

   task automatic test_latency();
      int exp_v[3];
      exp_v[0] = 1; exp_v[1] = 6; exp_v[2] = 126;
      sel = 1'b0;
      a = 6'd1;  b = 6'd1; step();
      a = 6'd2;  b = 6'd3; step();
      for (int k = 0; k < 3; k++) begin
         total++;
         if (out !== 12'(exp_v[k])) begin
            bad++; $display("FAIL latency_%0d: out=%0d expected=%0d", k, out, exp_v[k]);
         end
         if (k == 0) begin a = 6'd63; b = 6'd2; end
         step();
      end
   endtask

   task automatic test_concat();
      sel = 1'b1; a = 6'b101010; b = 6'b000111;
      step();
      sel = 1'b0;
      step();
      total++;
      if (out !== 12'b101010000111) begin
         bad++; $display("FAIL concat: out=%b expected=101010000111", out);
      end
      step();
      total++;
      if (out !== 12'd294) begin
         bad++; $display("FAIL concat_to_product: out=%0d expected=294", out);
      end
   endtask

   task automatic test_reset_midstream();
      sel = 1'b0; a = 6'd63; b = 6'd63;
      step();
      rst_n = 1'b0;
      #1;
      total++;
      if (out !== 12'd0) begin
         bad++; $display("FAIL midreset_clear: out=%0d expected=0", out);
      end
      step();
      rst_n = 1'b1;
      step();
      total++;
      if (out !== 12'd0) begin
         bad++; $display("FAIL midreset_flushed: out=%0d expected=0", out);
      end
      step();
      total++;
      if (out !== 12'd3969) begin
         bad++; $display("FAIL midreset_result: out=%0d expected=3969", out);
      end
   endtask

   task automatic test_back_to_back();
      int exp_q[$];
      int ra, rb;
      bit rs;
      for (int n = 0; n < 400; n++) begin
         ra = int'($urandom_range(MAXV, 0));
         rb = int'($urandom_range(MAXV, 0));
         rs = 1'($urandom_range(1, 0));
         a = W'(ra); b = W'(rb); sel = rs;
         exp_q.push_back(model(ra, rb, rs));
         step();
         if (exp_q.size() == 2) begin
            total++;
            if (out !== 12'(exp_q[0])) begin
               bad++; $display("FAIL back_to_back n=%0d: out=%0d expected=%0d", n, out, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic test_stable();
      sel = 1'b0; a = 6'd63; b = 6'd0;
      step(); step();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (out !== 12'd0) begin
            bad++; $display("FAIL stable_zero k=%0d: out=%0d expected=0", k, out);
         end
         step();
      end
   endtask

`ifdef MUX2_TOP_VALID_EN
   task automatic test_valid();
      in_valid = 1'b0;
      step(); step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL valid_idle: out_valid=%0b expected=0", out_valid);
      end
      sel = 1'b0; a = 6'd4; b = 6'd9; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL valid_early: out_valid=%0b expected=0", out_valid);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out !== 12'd36) begin
         bad++; $display("FAIL valid_pulse: out_valid=%0b out=%0d expected 1/36", out_valid, out);
      end
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL valid_single: out_valid=%0b expected=0", out_valid);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0; a = '0; b = '0; sel = 1'b0;
`ifdef MUX2_TOP_VALID_EN
      in_valid = 1'b0;
`endif
      test_reset();
      test_latency();
      test_concat();
      test_reset_midstream();
      test_stable();
      test_back_to_back();
      test_exhaustive();
`ifdef MUX2_TOP_VALID_EN
      test_valid();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
